// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue to instruction memory,
// in-order response capture into a prefetch FIFO, and redirect flush handling.
module fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic [31:0]   tail_pc;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   word_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop;
   logic [CW:0]   credit_used;
   logic [31:0]   redirect_aligned;
   logic          grant;
   logic          rsp;
   logic          push;
   logic          pop;

   // Every outstanding request owns a FIFO slot, so the buffer can never overflow.
   assign credit_used      = {1'b0, outstanding} + {1'b0, count};
   assign mem_req          = rst_n && !redirect && (credit_used < (CW+1)'(DEPTH));
   assign mem_addr         = fetch_pc;
   assign grant            = mem_req && mem_gnt;
   assign rsp              = mem_rvalid && (outstanding != '0);
   assign push             = rsp && (drop == '0) && !redirect;
   assign pop              = inst_valid && inst_ready && !redirect;
   assign redirect_aligned = {redirect_pc[31:2], 2'b00};

   assign inst_valid = (count != '0);
   assign inst       = inst_valid ? word_mem[rd_ptr] : '0;
   assign inst_pc    = inst_valid ? pc_mem[rd_ptr]   : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         tail_pc     <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else if (redirect) begin
         // Every response still in flight belongs to the old path and must be dropped.
         fetch_pc    <= redirect_aligned;
         tail_pc     <= redirect_aligned;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= outstanding - CW'(rsp);
         drop        <= outstanding - CW'(rsp);
      end else begin
         if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (push) begin
            wr_ptr  <= wr_ptr + PW'(1);
            tail_pc <= tail_pc + 32'd4;
         end
         if (rsp && (drop != '0)) begin
            drop <= drop - CW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count       <= count + CW'(push) - CW'(pop);
         outstanding <= outstanding + CW'(grant) - CW'(rsp);
      end
   end

   // Storage needs no reset: the head is masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= tail_pc;
         word_mem[wr_ptr] <= mem_rdata;
      end
   end

endmodule
